uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
Scheduler that shares the UART transmitter between two byte-stream requesters and sequences each byte into it. Requester A sends 16-bit results as two frames, LSB first. Requester B sends single 8-bit bytes. The block drives the transmitter's parallel data and data-valid inputs, and paces each byte on the transmitter's busy flag plus an optional inter-frame gap. It sits between the system controller and the UART transmitter.

Parameters:
- GAP_CYCLES, default 0: idle cycles inserted after each byte completes; 0 means no gap.
- BUSY_TIMEOUT, default 15: maximum number of cycles to wait for TX_BUSY to rise after a valid pulse (range 1..255).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- A_VALID  in  1  requester A has a 16-bit word.
- A_DATA  in  16  requester A word.
- A_READY  out  1  A word accepted this cycle.
- B_VALID  in  1  requester B has a byte.
- B_DATA  in  8  requester B byte.
- B_READY  out  1  B byte accepted this cycle.
- TX_BUSY  in  1  transmitter busy flag, synchronous to CLK.
- TX_P_DATA  out  8  byte presented to the transmitter.
- TX_DATA_VALID  out  1  one-cycle load strobe to the transmitter.
- SCHED_BUSY  out  1  high whenever state is not IDLE.
- TIMEOUT_ERR  out  1  one-cycle pulse when TX_BUSY fails to rise.

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST is synchronous and active-high. RST=1 at any edge, including mid-message, gives the following next cycle:
  - state IDLE;
  - TX_P_DATA=0x00, TX_DATA_VALID=0, TIMEOUT_ERR=0, SCHED_BUSY=0;
  - round-robin pointer = A;
  - latched message discarded.
- States: IDLE, LOAD, WAIT_HI, WAIT_LO, GAP.
- IDLE, arbitration:
  - A_READY/B_READY are combinational and only ever high in IDLE, and only for the granted requester whose VALID is high.
  - If only one VALID is high, that requester is granted.
  - If both are high, the requester named by the pointer is granted; the pointer then flips to the other requester.
  - A grant with no contention also sets the pointer to the other requester.
- Accept (VALID & READY):
  - A: bytes A_DATA[7:0] then A_DATA[15:8] are latched; byte count = 2.
  - B: B_DATA is latched; byte count = 1.
  - Next state LOAD.
- Requests outside IDLE: READY stays low and nothing is buffered. The requester must hold VALID and its data.
- LOAD:
  - TX_P_DATA = current byte (registered).
  - If TX_BUSY=0: TX_DATA_VALID=1 for exactly one cycle, then go to WAIT_HI with the timeout counter cleared.
  - If TX_BUSY=1: stay in LOAD with TX_DATA_VALID=0.
  - Latency: accept at edge N gives TX_DATA_VALID high in cycle N+1 when TX_BUSY is low.
- TX_P_DATA is held stable from LOAD until WAIT_LO exits.
- WAIT_HI:
  - TX_BUSY=1 moves to WAIT_LO.
  - Otherwise the counter increments. When TX_BUSY has been low for BUSY_TIMEOUT consecutive WAIT_HI cycles:
    - TIMEOUT_ERR=1 for one cycle;
    - remaining bytes of the message are dropped;
    - next state IDLE (no gap).
- WAIT_LO:
  - TX_BUSY=0 moves to GAP, or past GAP if GAP_CYCLES=0.
  - No timeout in this state.
- GAP:
  - Counts GAP_CYCLES cycles.
  - Then, if bytes remain: advance to the next byte and go to LOAD.
  - Otherwise go to IDLE.
- Counter widths: the gap counter is sized by $clog2(GAP_CYCLES+1), minimum 1 bit. The timeout counter is 8 bits.

Optional Feature:
Macro TX_SCHED_STATS_EN.
- Defined:
  - Adds output BYTE_CNT[15:0], reset to 0.
  - Increments by 1 on each WAIT_HI to WAIT_LO transition, i.e. each byte the transmitter accepted.
  - Wraps 0xFFFF to 0x0000.
  - Timed-out bytes are not counted.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. B_VALID=1, B_DATA=0xA5; TX_BUSY model rises 1 cycle after the strobe and stays high 10 cycles -> B_READY high for 1 cycle; single TX_DATA_VALID pulse with TX_P_DATA=0xA5; SCHED_BUSY falls after TX_BUSY falls; TIMEOUT_ERR stays 0.
2. A_VALID=1, A_DATA=0x1234, GAP_CYCLES=2 -> two strobes, TX_P_DATA=0x34 then 0x12. The second strobe comes exactly 3 cycles after TX_BUSY falls for the first byte (2 GAP cycles, then LOAD).
3. A_VALID and B_VALID held high continuously from reset -> grant order A, B, A, B. Frames 0x34, 0x12, B byte, 0x34, ...
4. A message with TX_BUSY held 0 and BUSY_TIMEOUT=15 -> one strobe for 0x34; TIMEOUT_ERR pulse after 15 low cycles in WAIT_HI; 0x12 never sent; IDLE with A_READY available the next cycle.
5. TX_BUSY=1 at accept for 5 cycles -> TX_DATA_VALID stays low until the first cycle TX_BUSY=0, then pulses once.
6. RST=1 during WAIT_LO of byte 0 of an A message -> next cycle all outputs at reset values; no strobe for 0x12; pointer back to A (tie then grants A).

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Shares one UART transmitter between two requesters and feeds it one byte at
// a time. Requester A supplies 16-bit words sent as two frames (low byte
// first); requester B supplies single bytes. Each byte is strobed into the
// transmitter once it is idle, then the scheduler follows TX_BUSY high and
// low again, inserts an optional gap and moves on to the next byte.
//
// Parameters:
//   GAP_CYCLES   idle cycles inserted after each byte completes (0 = none)
//   BUSY_TIMEOUT cycles to wait for TX_BUSY to rise after a strobe (1..255)
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   A_VALID/A_DATA      16-bit word request, A_READY = accepted this cycle
//   B_VALID/B_DATA      8-bit byte request,  B_READY = accepted this cycle
//   TX_BUSY             transmitter busy flag (synchronous to CLK)
//   TX_P_DATA           byte presented to the transmitter (registered)
//   TX_DATA_VALID       one-cycle load strobe to the transmitter
//   SCHED_BUSY          high whenever the scheduler is not idle
//   TIMEOUT_ERR         one-cycle pulse when TX_BUSY never rose
//   BYTE_CNT            bytes accepted by the transmitter (only with
//                       TX_SCHED_STATS_EN defined)
//
// Build option: define TX_SCHED_STATS_EN to add the BYTE_CNT statistics port.
module uart_tx_sched #(
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        A_VALID,
  input  logic [15:0] A_DATA,
  output logic        A_READY,
  input  logic        B_VALID,
  input  logic [7:0]  B_DATA,
  output logic        B_READY,
  input  logic        TX_BUSY,
  output logic [7:0]  TX_P_DATA,
  output logic        TX_DATA_VALID,
  output logic        SCHED_BUSY,
  output logic        TIMEOUT_ERR
`ifdef TX_SCHED_STATS_EN
  ,
  output logic [15:0] BYTE_CNT
`endif
);

  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [7:0]    TO_LAST  = 8'(BUSY_TIMEOUT - 1);
  localparam bit            NO_GAP   = (GAP_CYCLES == 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t        state_r, state_n;
  logic          ptr_r, ptr_n;          // 0: A has priority on a tie, 1: B
  logic [7:0]    tx_data_r, tx_data_n;
  logic [7:0]    hi_byte_r, hi_byte_n;  // second byte of an A word
  logic          more_r, more_n;        // second byte still to send
  logic [7:0]    to_cnt_r, to_cnt_n;
  logic [GW-1:0] gap_cnt_r, gap_cnt_n;
  logic          timeout_r, timeout_n;
  logic          grant_a_s, grant_b_s;

  // Arbitration: only in IDLE and never while reset is held
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if ((state_r == S_IDLE) && !RST) begin
      grant_a_s = A_VALID && (!B_VALID || (ptr_r == 1'b0));
      grant_b_s = B_VALID && (!A_VALID || (ptr_r == 1'b1));
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  assign A_READY       = grant_a_s;
  assign B_READY       = grant_b_s;
  // The strobe must react to TX_BUSY in the same cycle so a load never
  // collides with a transmitter that is still busy.
  assign TX_DATA_VALID = (state_r == S_LOAD) && !TX_BUSY;
  assign TX_P_DATA     = tx_data_r;
  assign SCHED_BUSY    = (state_r != S_IDLE);
  assign TIMEOUT_ERR   = timeout_r;

  // Next-state and datapath update logic
  always_comb begin
    state_n   = state_r;
    ptr_n     = ptr_r;
    tx_data_n = tx_data_r;
    hi_byte_n = hi_byte_r;
    more_n    = more_r;
    to_cnt_n  = to_cnt_r;
    gap_cnt_n = gap_cnt_r;
    timeout_n = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (grant_a_s) begin
          tx_data_n = A_DATA[7:0];
          hi_byte_n = A_DATA[15:8];
          more_n    = 1'b1;
          ptr_n     = 1'b1;
          state_n   = S_LOAD;
        end else if (grant_b_s) begin
          tx_data_n = B_DATA;
          more_n    = 1'b0;
          ptr_n     = 1'b0;
          state_n   = S_LOAD;
        end else begin
          state_n   = S_IDLE;
        end
      end
      S_LOAD: begin
        if (!TX_BUSY) begin
          to_cnt_n = 8'h00;
          state_n  = S_WAIT_HI;
        end else begin
          state_n  = S_LOAD;
        end
      end
      S_WAIT_HI: begin
        if (TX_BUSY) begin
          state_n   = S_WAIT_LO;
        end else if (to_cnt_r == TO_LAST) begin
          // Transmitter never took the byte: abandon the rest of the message
          timeout_n = 1'b1;
          more_n    = 1'b0;
          state_n   = S_IDLE;
        end else begin
          to_cnt_n  = to_cnt_r + 8'd1;
        end
      end
      S_WAIT_LO: begin
        if (TX_BUSY) begin
          state_n = S_WAIT_LO;
        end else if (!NO_GAP) begin
          gap_cnt_n = {GW{1'b0}};
          state_n   = S_GAP;
        end else if (more_r) begin
          tx_data_n = hi_byte_r;
          more_n    = 1'b0;
          state_n   = S_LOAD;
        end else begin
          state_n   = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt_r != GAP_LAST) begin
          gap_cnt_n = gap_cnt_r + GW'(1);
        end else if (more_r) begin
          tx_data_n = hi_byte_r;
          more_n    = 1'b0;
          state_n   = S_LOAD;
        end else begin
          state_n   = S_IDLE;
        end
      end
      default: begin
        more_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= S_IDLE;
      ptr_r     <= 1'b0;
      tx_data_r <= 8'h00;
      hi_byte_r <= 8'h00;
      more_r    <= 1'b0;
      to_cnt_r  <= 8'h00;
      gap_cnt_r <= {GW{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      ptr_r     <= ptr_n;
      tx_data_r <= tx_data_n;
      hi_byte_r <= hi_byte_n;
      more_r    <= more_n;
      to_cnt_r  <= to_cnt_n;
      gap_cnt_r <= gap_cnt_n;
      timeout_r <= timeout_n;
    end
  end

`ifdef TX_SCHED_STATS_EN
  logic [15:0] byte_cnt_r;

  // Count bytes the transmitter actually accepted (busy rose after strobe)
  always_ff @(posedge CLK) begin
    if (RST) begin
      byte_cnt_r <= 16'h0000;
    end else if ((state_r == S_WAIT_HI) && TX_BUSY) begin
      byte_cnt_r <= byte_cnt_r + 16'd1;
    end else begin
      byte_cnt_r <= byte_cnt_r;
    end
  end

  assign BYTE_CNT = byte_cnt_r;
`endif

endmodule
